// File: rtl/reset_sequencer_if.sv
// Handshake bundle between the reset sequencer and the SoC and the reset domains.
//   sw_rst_req_i  : one-cycle software request to abort and re-run the sequence
//   ready_i       : per-stage "out of reset" acknowledge (level)
//   rst_o         : per-stage reset, active-high, bit 0 released first
//   busy_o        : sequence in progress
//   seq_done_o    : all stages released and acknowledged
//   timeout_err_o : sticky acknowledge-timeout flag
//   err_stage_o   : index of the stage that timed out
// The slave modport is the sequencer side; the master modport is the SoC/bench side.
interface reset_sequencer_if #(
  parameter int NUM_STAGES = 4
);
  localparam int ESW = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;

  logic                  sw_rst_req_i;
  logic [NUM_STAGES-1:0] ready_i;
  logic [NUM_STAGES-1:0] rst_o;
  logic                  busy_o;
  logic                  seq_done_o;
  logic                  timeout_err_o;
  logic [ESW-1:0]        err_stage_o;

  modport slave (
    input  sw_rst_req_i, ready_i,
    output rst_o, busy_o, seq_done_o, timeout_err_o, err_stage_o
  );

  modport master (
    output sw_rst_req_i, ready_i,
    input  rst_o, busy_o, seq_done_o, timeout_err_o, err_stage_o
  );
endinterface

// File: rtl/reset_sequencer.sv
// Reset sequencer: synchronizes deassertion of the board reset to clk, then
// releases NUM_STAGES reset domains one after another. Each release is preceded
// by HOLD_CYCLES cycles of hold and followed by a wait for that stage's ready
// acknowledge (bounded by ACK_TIMEOUT unless it is 0). A software request
// restarts the sequence from the first hold.
// Ports:
//   clk         : system clock, rising edge
//   async_rst_i : board reset, asynchronous assert, active-high
//   bus         : reset_sequencer_if.slave (request/ready in, resets/status out)
module reset_sequencer #(
  parameter int NUM_STAGES  = 4,
  parameter int SYNC_STAGES = 2,
  parameter int HOLD_CYCLES = 8,
  parameter int ACK_TIMEOUT = 255,
  parameter int CNT_W       = 8
) (
  input  logic               clk,
  input  logic               async_rst_i,
  reset_sequencer_if.slave   bus
);
  localparam int ESW = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;

  typedef enum logic [2:0] {
    ST_RESET    = 3'd0,
    ST_HOLD     = 3'd1,
    ST_WAIT_ACK = 3'd2,
    ST_DONE     = 3'd3,
    ST_ERROR    = 3'd4
  } state_t;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   irst;

  state_t                 state_q, state_d;
  logic [ESW-1:0]         stage_q, stage_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [NUM_STAGES-1:0]  rst_q, rst_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   terr_q, terr_d;
  logic [ESW-1:0]         estg_q, estg_d;

  // Deassertion synchronizer: set instantly by the board reset, drained by clk.
  always_ff @(posedge clk or posedge async_rst_i) begin
    if (async_rst_i) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b0};
    end
  end

  // irst rises together with async_rst_i (async set) and falls only on clk.
  assign irst = sync_q[SYNC_STAGES-1];

  // Sequencer state and registered outputs, held in reset by the internal reset.
  always_ff @(posedge clk or posedge irst) begin
    if (irst) begin
      state_q <= ST_RESET;
      stage_q <= '0;
      cnt_q   <= '0;
      rst_q   <= '1;
      busy_q  <= 1'b1;
      done_q  <= 1'b0;
      terr_q  <= 1'b0;
      estg_q  <= '0;
    end else begin
      state_q <= state_d;
      stage_q <= stage_d;
      cnt_q   <= cnt_d;
      rst_q   <= rst_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      terr_q  <= terr_d;
      estg_q  <= estg_d;
    end
  end

  // Next-state and next-output logic; the software request overrides everything.
  always_comb begin
    state_d = state_q;
    stage_d = stage_q;
    cnt_d   = cnt_q;
    rst_d   = rst_q;
    done_d  = done_q;
    terr_d  = terr_q;
    estg_d  = estg_q;

    if (bus.sw_rst_req_i) begin
      state_d = ST_HOLD;
      stage_d = '0;
      cnt_d   = '0;
      rst_d   = '1;
      done_d  = 1'b0;
      terr_d  = 1'b0;
      estg_d  = '0;
    end else begin
      case (state_q)
        ST_RESET: begin
          state_d = ST_HOLD;
          stage_d = '0;
          cnt_d   = '0;
        end
        ST_HOLD: begin
          if (cnt_q == CNT_W'(HOLD_CYCLES - 1)) begin
            rst_d[stage_q] = 1'b0;
            cnt_d          = '0;
            state_d        = ST_WAIT_ACK;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_WAIT_ACK: begin
          // Ready wins over a timeout landing on the same edge.
          if (bus.ready_i[stage_q]) begin
            if (stage_q == ESW'(NUM_STAGES - 1)) begin
              state_d = ST_DONE;
              done_d  = 1'b1;
            end else begin
              stage_d = stage_q + ESW'(1);
              cnt_d   = '0;
              state_d = ST_HOLD;
            end
          end else if ((ACK_TIMEOUT != 0) && (cnt_q == CNT_W'(ACK_TIMEOUT - 1))) begin
            state_d = ST_ERROR;
            terr_d  = 1'b1;
            estg_d  = stage_q;
            rst_d   = '1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_DONE: begin
          state_d = ST_DONE;
        end
        ST_ERROR: begin
          state_d = ST_ERROR;
        end
        default: begin
          state_d = ST_RESET;
          rst_d   = '1;
        end
      endcase
    end

    busy_d = (state_d == ST_RESET) || (state_d == ST_HOLD) || (state_d == ST_WAIT_ACK);
  end

  assign bus.rst_o         = rst_q;
  assign bus.busy_o        = busy_q;
  assign bus.seq_done_o    = done_q;
  assign bus.timeout_err_o = terr_q;
  assign bus.err_stage_o   = estg_q;
endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer. Two instances share clk and the board reset:
// dut_a uses the default ACK_TIMEOUT (255), dut_b uses ACK_TIMEOUT=16.
// Each scenario is a table of {edge, ready, sw request, expected outputs};
// expectations are pushed to a scoreboard queue when the stimulus for that
// edge is driven and popped/compared 1 ns after the edge. Edge numbers are
// counted from the release of the board reset (first edge after release = 1).
module tb_reset_sequencer;
  logic clk = 1'b0;
  logic async_rst = 1'b1;
  int   edge_cnt = 0;
  int   base = 0;
  int   errors = 0;
  int   checks = 0;

  reset_sequencer_if #(.NUM_STAGES(4)) if_a ();
  reset_sequencer_if #(.NUM_STAGES(4)) if_b ();

  reset_sequencer #(.ACK_TIMEOUT(255)) dut_a (
    .clk         (clk),
    .async_rst_i (async_rst),
    .bus         (if_a.slave)
  );

  reset_sequencer #(.ACK_TIMEOUT(16)) dut_b (
    .clk         (clk),
    .async_rst_i (async_rst),
    .bus         (if_b.slave)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  // exp packing: {rst[3:0], busy, done, terr, err_stage[1:0]}
  typedef struct {
    int         rel;
    logic [3:0] rdy;
    logic       sw;
    logic [8:0] exp;
  } vec_t;

  typedef struct {
    int         abs_e;
    int         which;
    logic [8:0] exp;
    string      name;
  } sb_t;

  vec_t tbl[$];
  sb_t  sb[$];

  function automatic vec_t v(int rel, logic [3:0] rdy, logic sw, logic [3:0] r,
                             logic b, logic d, logic t, logic [1:0] e);
    vec_t x;
    x.rel = rel;
    x.rdy = rdy;
    x.sw  = sw;
    x.exp = {r, b, d, t, e};
    return x;
  endfunction

  function automatic logic [8:0] actual(int which);
    if (which == 0)
      return {if_a.rst_o, if_a.busy_o, if_a.seq_done_o, if_a.timeout_err_o, if_a.err_stage_o};
    else
      return {if_b.rst_o, if_b.busy_o, if_b.seq_done_o, if_b.timeout_err_o, if_b.err_stage_o};
  endfunction

  task automatic cmp(string name, int which, logic [8:0] exp);
    logic [8:0] act;
    act = actual(which);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got rst=%b busy=%b done=%b terr=%b estg=%0d, want rst=%b busy=%b done=%b terr=%b estg=%0d",
               name, act[8:5], act[4], act[3], act[2], act[1:0],
               exp[8:5], exp[4], exp[3], exp[2], exp[1:0]);
    end
  endtask

  // Compare every scoreboard entry whose edge has been reached.
  task automatic drain();
    sb_t e;
    while (sb.size() > 0 && sb[0].abs_e <= edge_cnt) begin
      e = sb.pop_front();
      cmp(e.name, e.which, e.exp);
    end
  endtask

  // One clock: edge, sample at +1, return at +2 ready to drive.
  task automatic step();
    @(posedge clk);
    #1;
    drain();
    #1;
  endtask

  task automatic goto_rel(int rel);
    while (edge_cnt < base + rel) step();
  endtask

  task automatic drive(int which, logic [3:0] rdy, logic sw);
    if (which == 0) begin
      if_a.ready_i      = rdy;
      if_a.sw_rst_req_i = sw;
    end else begin
      if_b.ready_i      = rdy;
      if_b.sw_rst_req_i = sw;
    end
  endtask

  task automatic run_tbl(int which, string tag);
    sb_t e;
    for (int i = 0; i < tbl.size(); i++) begin
      goto_rel(tbl[i].rel - 1);
      drive(which, tbl[i].rdy, tbl[i].sw);
      e.abs_e = base + tbl[i].rel;
      e.which = which;
      e.exp   = tbl[i].exp;
      e.name  = $sformatf("%s_e%0d", tag, tbl[i].rel);
      sb.push_back(e);
    end
    goto_rel(tbl[tbl.size()-1].rel);
  endtask

  task automatic do_reset();
    if_a.sw_rst_req_i = 1'b0;
    if_b.sw_rst_req_i = 1'b0;
    async_rst = 1'b1;
    repeat (3) step();
    cmp("reset_state_a", 0, {4'b1111, 1'b1, 1'b0, 1'b0, 2'd0});
    cmp("reset_state_b", 1, {4'b1111, 1'b1, 1'b0, 1'b0, 2'd0});
    async_rst = 1'b0;
    base = edge_cnt;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, edge=%0d", edge_cnt);
    $fatal(1);
  end

  initial begin
    if_a.ready_i = 4'b0000; if_a.sw_rst_req_i = 1'b0;
    if_b.ready_i = 4'b0000; if_b.sw_rst_req_i = 1'b0;

    // Immediate ready: releases at 11/20/29/38, done at 39; then a ready drop
    // is ignored in DONE and a software request replays the whole sequence.
    do_reset();
    tbl.delete();
    tbl.push_back(v( 1, 4'b1111, 1'b0, 4'b1111, 1'b1, 1'b0, 1'b0, 2'd0));
    tbl.push_back(v( 3, 4'b1111, 1'b0, 4'b1111, 1'b1, 1'b0, 1'b0, 2'd0));
    tbl.push_back(v(10, 4'b1111, 1'b0, 4'b1111, 1'b1, 1'b0, 1'b0, 2'd0));
    tbl.push_back(v(11, 4'b1111, 1'b0, 4'b1110, 1'b1, 1'b0, 1'b0, 2'd0));
    tbl.push_back(v(19, 4'b1111, 1'b0, 4'b1110, 1'b1, 1'b0, 1'b0, 2'd0));
    tbl.push_back(v(20, 4'b1111, 1'b0, 4'b1100, 1'b1, 1'b0, 1'b0, 2'd0));
    tbl.push_back(v(28, 4'b1111, 1'b0, 4'b1100, 1'b1, 1'b0, 1'b0, 2'd0));
    tbl.push_back(v(29, 4'b1111, 1'b0, 4'b1000, 1'b1, 1'b0, 1'b0, 2'd0));
    tbl.push_back(v(37, 4'b1111, 1'b0, 4'b1000, 1'b1, 1'b0, 1'b0, 2'd0));
    tbl.push_back(v(38, 4'b1111, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 2'd0));
    tbl.push_back(v(39, 4'b1111, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b0, 2'd0));
    tbl.push_back(v(45, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b0, 2'd0));
    tbl.push_back(v(46, 4'b1111, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b0, 2'd0));
    tbl.push_back(v(47, 4'b1111, 1'b1, 4'b1111, 1'b1, 1'b0, 1'b0, 2'd0));
    tbl.push_back(v(48, 4'b1111, 1'b0, 4'b1111, 1'b1, 1'b0, 1'b0, 2'd0));
    tbl.push_back(v(54, 4'b1111, 1'b0, 4'b1111, 1'b1, 1'b0, 1'b0, 2'd0));
    tbl.push_back(v(55, 4'b1111, 1'b0, 4'b1110, 1'b1, 1'b0, 1'b0, 2'd0));
    tbl.push_back(v(64, 4'b1111, 1'b0, 4'b1100, 1'b1, 1'b0, 1'b0, 2'd0));
    tbl.push_back(v(73, 4'b1111, 1'b0, 4'b1000, 1'b1, 1'b0, 1'b0, 2'd0));
    tbl.push_back(v(82, 4'b1111, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 2'd0));
    tbl.push_back(v(83, 4'b1111, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b0, 2'd0));
    run_tbl(0, "seq_sw");

    // Stage 1 acknowledges 5 cycles late: stage 2 released 14 edges after stage 1.
    do_reset();
    tbl.delete();
    tbl.push_back(v( 1, 4'b1101, 1'b0, 4'b1111, 1'b1, 1'b0, 1'b0, 2'd0));
    tbl.push_back(v(11, 4'b1101, 1'b0, 4'b1110, 1'b1, 1'b0, 1'b0, 2'd0));
    tbl.push_back(v(20, 4'b1101, 1'b0, 4'b1100, 1'b1, 1'b0, 1'b0, 2'd0));
    tbl.push_back(v(25, 4'b1101, 1'b0, 4'b1100, 1'b1, 1'b0, 1'b0, 2'd0));
    tbl.push_back(v(26, 4'b1111, 1'b0, 4'b1100, 1'b1, 1'b0, 1'b0, 2'd0));
    tbl.push_back(v(33, 4'b1111, 1'b0, 4'b1100, 1'b1, 1'b0, 1'b0, 2'd0));
    tbl.push_back(v(34, 4'b1111, 1'b0, 4'b1000, 1'b1, 1'b0, 1'b0, 2'd0));
    tbl.push_back(v(42, 4'b1111, 1'b0, 4'b1000, 1'b1, 1'b0, 1'b0, 2'd0));
    tbl.push_back(v(43, 4'b1111, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 2'd0));
    tbl.push_back(v(44, 4'b1111, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b0, 2'd0));
    run_tbl(0, "late_ack");

    // Timeout on stage 0 (ERROR at edge 27), ERROR holds, then a software
    // request with ready present clears the flags and restarts.
    do_reset();
    tbl.delete();
    tbl.push_back(v( 1, 4'b1110, 1'b0, 4'b1111, 1'b1, 1'b0, 1'b0, 2'd0));
    tbl.push_back(v(11, 4'b1110, 1'b0, 4'b1110, 1'b1, 1'b0, 1'b0, 2'd0));
    tbl.push_back(v(26, 4'b1110, 1'b0, 4'b1110, 1'b1, 1'b0, 1'b0, 2'd0));
    tbl.push_back(v(27, 4'b1110, 1'b0, 4'b1111, 1'b0, 1'b0, 1'b1, 2'd0));
    tbl.push_back(v(30, 4'b1111, 1'b0, 4'b1111, 1'b0, 1'b0, 1'b1, 2'd0));
    tbl.push_back(v(31, 4'b1111, 1'b1, 4'b1111, 1'b1, 1'b0, 1'b0, 2'd0));
    tbl.push_back(v(32, 4'b1111, 1'b0, 4'b1111, 1'b1, 1'b0, 1'b0, 2'd0));
    tbl.push_back(v(38, 4'b1111, 1'b0, 4'b1111, 1'b1, 1'b0, 1'b0, 2'd0));
    tbl.push_back(v(39, 4'b1111, 1'b0, 4'b1110, 1'b1, 1'b0, 1'b0, 2'd0));
    tbl.push_back(v(40, 4'b1111, 1'b0, 4'b1110, 1'b1, 1'b0, 1'b0, 2'd0));
    tbl.push_back(v(48, 4'b1111, 1'b0, 4'b1100, 1'b1, 1'b0, 1'b0, 2'd0));
    run_tbl(1, "timeout_recover");

    // Ready arrives on the very edge the timeout would fire: no error.
    do_reset();
    tbl.delete();
    tbl.push_back(v( 1, 4'b1110, 1'b0, 4'b1111, 1'b1, 1'b0, 1'b0, 2'd0));
    tbl.push_back(v(11, 4'b1110, 1'b0, 4'b1110, 1'b1, 1'b0, 1'b0, 2'd0));
    tbl.push_back(v(26, 4'b1110, 1'b0, 4'b1110, 1'b1, 1'b0, 1'b0, 2'd0));
    tbl.push_back(v(27, 4'b1111, 1'b0, 4'b1110, 1'b1, 1'b0, 1'b0, 2'd0));
    tbl.push_back(v(35, 4'b1111, 1'b0, 4'b1100, 1'b1, 1'b0, 1'b0, 2'd0));
    run_tbl(1, "ready_at_limit");

    // Timeout on stage 2 reports err_stage=2.
    do_reset();
    tbl.delete();
    tbl.push_back(v( 1, 4'b1011, 1'b0, 4'b1111, 1'b1, 1'b0, 1'b0, 2'd0));
    tbl.push_back(v(29, 4'b1011, 1'b0, 4'b1000, 1'b1, 1'b0, 1'b0, 2'd0));
    tbl.push_back(v(44, 4'b1011, 1'b0, 4'b1000, 1'b1, 1'b0, 1'b0, 2'd0));
    tbl.push_back(v(45, 4'b1011, 1'b0, 4'b1111, 1'b0, 1'b0, 1'b1, 2'd2));
    run_tbl(1, "timeout_stage2");

    // Board reset asserted between edges during the stage-2 hold.
    do_reset();
    tbl.delete();
    tbl.push_back(v( 1, 4'b1111, 1'b0, 4'b1111, 1'b1, 1'b0, 1'b0, 2'd0));
    tbl.push_back(v(20, 4'b1111, 1'b0, 4'b1100, 1'b1, 1'b0, 1'b0, 2'd0));
    tbl.push_back(v(24, 4'b1111, 1'b0, 4'b1100, 1'b1, 1'b0, 1'b0, 2'd0));
    run_tbl(0, "mid_hold");
    #3;
    async_rst = 1'b1;
    #1;
    cmp("async_immediate", 0, {4'b1111, 1'b1, 1'b0, 1'b0, 2'd0});
    do_reset();
    tbl.delete();
    tbl.push_back(v( 1, 4'b1111, 1'b0, 4'b1111, 1'b1, 1'b0, 1'b0, 2'd0));
    tbl.push_back(v(10, 4'b1111, 1'b0, 4'b1111, 1'b1, 1'b0, 1'b0, 2'd0));
    tbl.push_back(v(11, 4'b1111, 1'b0, 4'b1110, 1'b1, 1'b0, 1'b0, 2'd0));
    run_tbl(0, "after_async");

    step();
    if (sb.size() != 0) begin
      errors += sb.size();
      checks += sb.size();
      $display("FAIL sb_leftover: got %0d unchecked entries, want 0", sb.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
